midi_note_rx: RTL

//   Serial MIDI front end that generates the NOTE code driven into the note-to-DDS/DDS/waveform chain.
//   It receives a 31250-baud 8N1 MIDI stream, parses Note On and Note Off messages on one channel,
//   and holds a monophonic last-note-priority NOTE/VELOCITY/GATE set for the synthesiser core.

---
 rtl/midi_pkg.sv | 23 ++
 rtl/midi_uart_rx.sv | 102 ++++++++++
 rtl/midi_note_rx.sv | 110 +++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared constants, state encodings and event payload for the MIDI note receiver.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  typedef enum logic [1:0] {NO_STATUS, WAIT_KEY, WAIT_VEL} parse_state_t;

  // Complete key/velocity pair handed from the parser to the output stage
  typedef struct packed {
    logic       on;
    logic [6:0] key;
    logic [6:0] vel;
  } note_event_t;

  // Clocks per serial bit, rounded to nearest
  function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver: input synchroniser, start validation, bit-centre sampling.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned DIV  = bit_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV) + 1;

  logic sync1;
  logic rx_s;
  logic rx_prev;

  // Synchroniser plus one delayed copy for falling-edge detection; idle level is 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_state_t      state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick_c;

  // Start bit is checked half a bit in; every later sample is one full bit on
  always_comb begin
    tick_c = 1'b0;
    if (state == START) tick_c = (cnt == CW'(HALF - 1));
    else                tick_c = (cnt == CW'(DIV - 1));
  end

  // Falling edge re-arms only after the line has been seen high, so a low
  // stop bit holds the receiver off until the line recovers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        default: begin
          if (!tick_c) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            case (state)
              START: begin
                if (rx_s) state <= IDLE;
                else      state <= DATA;
              end
              DATA: begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) state <= STOP;
              end
              STOP: begin
                if (rx_s) begin
                  rx_byte    <= shreg;
                  byte_valid <= 1'b1;
                end else begin
                  frame_err  <= 1'b1;
                end
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_note_rx.sv
// MIDI Note On/Off front end: single-channel running-status parser driving a
// monophonic last-note-priority NOTE/VELOCITY/GATE set.
module midi_note_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 31250,
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_in,
  output logic [7:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_uart (
    .clk       (clk),
    .reset     (reset),
    .rx        (midi_in),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  parse_state_t pstate;
  logic         run_on;
  logic [6:0]   key;
  note_event_t  ev;
  logic         ev_valid;

  logic is_rt_c;
  logic is_note_status_c;

  always_comb begin
    is_rt_c          = (rx_byte >= RT_MIN);
    is_note_status_c = (rx_byte[3:0] == 4'(CHANNEL)) &&
                       ((rx_byte[7:4] == ST_NOTE_ON) || (rx_byte[7:4] == ST_NOTE_OFF));
  end

  // Running-status parser; real-time bytes pass through without touching state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pstate   <= NO_STATUS;
      run_on   <= 1'b0;
      key      <= '0;
      ev       <= '0;
      ev_valid <= 1'b0;
    end else begin
      ev_valid <= 1'b0;
      if (byte_valid && !is_rt_c) begin
        if (rx_byte[7]) begin
          if (is_note_status_c) begin
            run_on <= (rx_byte[7:4] == ST_NOTE_ON);
            pstate <= WAIT_KEY;
          end else begin
            pstate <= NO_STATUS;
          end
        end else begin
          case (pstate)
            WAIT_KEY: begin
              key    <= rx_byte[6:0];
              pstate <= WAIT_VEL;
            end
            WAIT_VEL: begin
              ev.on    <= run_on;
              ev.key   <= key;
              ev.vel   <= rx_byte[6:0];
              ev_valid <= 1'b1;
              pstate   <= WAIT_KEY;
            end
            default: pstate <= NO_STATUS;
          endcase
        end
      end
    end
  end

  // Apply event; NOTE/VELOCITY are kept on release so the oscillator holds pitch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note       <= '0;
      velocity   <= '0;
      gate       <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (ev_valid) begin
        if (ev.on && (ev.vel != 7'd0)) begin
          note       <= {1'b0, ev.key};
          velocity   <= ev.vel;
          gate       <= 1'b1;
          note_valid <= 1'b1;
        end else if (ev.key == note[6:0]) begin
          gate <= 1'b0;
        end
      end
    end
  end

endmodule
